uart_rx_ctrl: RTL

- Receive-side sequencer for the UART. It owns the `uart_baud` divider through its `baud_clear` output and consumes the 6th/8th/10th/16th sample ticks.
- It detects start bits, takes a 2-of-3 majority vote on each bit, checks parity and stop, and hands each received character to the register/FIFO layer through a valid/ready hold interface.
- It sits between the synchronised RX pin and the RX data path.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_sampler.sv | 48 ++++
 rtl/uart_rx_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling rate and
// parity modes used by both the RX controller and the future TX controller.
package uart_pkg;

  localparam int SAMPLES_PER_BIT = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } parity_t;

  // 7-bit characters land in shreg[7:1] after shifting, so move them down.
  function automatic logic [7:0] align_data(input logic [7:0] shreg,
                                            input logic       data7);
    return data7 ? {1'b0, shreg[7:1]} : shreg;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX pin front end: synchroniser, falling-edge detect and the 2-of-3 vote
// over the 6th/8th/10th sample ticks of each bit.
module uart_rx_sampler #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_b,
  input  logic rx,
  input  logic sample_6th,
  input  logic sample_8th,
  input  logic sample_10th,
  output logic fall,
  output logic vote
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_prev;
  logic                   s6;
  logic                   s8;
  logic                   s10;
  logic                   v10;

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sync_q  <= '1;
      rx_prev <= 1'b1;
      s6      <= 1'b1;
      s8      <= 1'b1;
      s10     <= 1'b1;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rx};
      rx_prev <= rx_s;
      if (sample_6th)  s6  <= rx_s;
      if (sample_8th)  s8  <= rx_s;
      if (sample_10th) s10 <= rx_s;
    end
  end

  // On the 10th tick itself the live rx_s stands in for s10 so the FSM can
  // act on the vote in the same cycle.
  assign v10  = sample_10th ? rx_s : s10;
  assign vote = (s6 & s8) | (s6 & v10) | (s8 & v10);
  assign fall = rx_prev & ~rx_s;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detection, bit assembly, parity/stop checks
// and a single-entry valid/ready hold towards the register/FIFO layer.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       rx,
  input  logic       cfg_data7,
  input  logic       cfg_par_en,
  input  logic       cfg_par_odd,
  input  logic       baud_sample_6th,
  input  logic       baud_sample_8th,
  input  logic       baud_sample_10th,
  input  logic       baud_sample_16th,
  output logic       baud_clear,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_frame_err,
  output logic       rx_parity_err,
  output logic       rx_overrun,
  output logic       rx_busy
);

  rx_state_t  state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       par_err;
  logic       data7_q;
  logic       par_en_q;
  parity_t    par_mode_q;
  logic       fall;
  logic       vote;
  logic       complete;
  logic [2:0] last_bit;
  logic [7:0] frame_data;

  uart_rx_sampler #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sampler (
    .clk         (clk),
    .rst_b       (rst_b),
    .rx          (rx),
    .sample_6th  (baud_sample_6th),
    .sample_8th  (baud_sample_8th),
    .sample_10th (baud_sample_10th),
    .fall        (fall),
    .vote        (vote)
  );

  assign baud_clear = (state == IDLE) && fall;
  assign rx_busy    = (state != IDLE);
  assign complete   = (state == STOP) && baud_sample_10th;
  assign last_bit   = data7_q ? 3'd6 : 3'd7;
  assign frame_data = align_data(shreg, data7_q);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      shreg         <= '0;
      par_err       <= 1'b0;
      data7_q       <= 1'b0;
      par_en_q      <= 1'b0;
      par_mode_q    <= PAR_EVEN;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;

      case (state)
        IDLE: begin
          // Config is frozen here so mid-frame register writes cannot
          // corrupt the character being assembled.
          if (fall) begin
            state      <= START;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_err    <= 1'b0;
            data7_q    <= cfg_data7;
            par_en_q   <= cfg_par_en;
            par_mode_q <= parity_t'(cfg_par_odd);
          end
        end
        START: begin
          if (baud_sample_10th && vote) begin
            state <= IDLE;
          end else if (baud_sample_16th) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (baud_sample_10th) begin
            shreg <= {vote, shreg[7:1]};
          end
          if (baud_sample_16th) begin
            if (bit_cnt == last_bit) begin
              state <= par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        PARITY: begin
          if (baud_sample_10th) begin
            par_err <= vote ^ (^frame_data) ^ (par_mode_q == PAR_ODD);
          end
          if (baud_sample_16th) begin
            state <= STOP;
          end
        end
        STOP: begin
          // Finishing at mid-stop lets us catch a start bit that arrives
          // up to half a bit early.
          if (baud_sample_10th) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (complete) begin
        if (!rx_valid || rx_ready) begin
          rx_data       <= frame_data;
          rx_frame_err  <= ~vote;
          rx_parity_err <= par_err;
          rx_valid      <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  a_overrun_while_held: assert property (
    @(posedge clk) disable iff (!rst_b) rx_overrun |-> rx_valid);

  a_valid_from_stop: assert property (
    @(posedge clk) disable iff (!rst_b) $rose(rx_valid) |-> $past(state) == STOP);

endmodule
